// File: rtl/ip_tx_arb2.sv
`default_nettype none
// ============================================================================
// Module   : ip_tx_arb2
// Purpose  : Two-input IP transmit arbiter. Grants one source at a time,
//            registers its IP header, then passes its payload frame through
//            to the single IP TX path until tlast, and re-arbitrates.
// Revision : 1.0 - initial release
// ============================================================================
module ip_tx_arb2 #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    // Source 0 (ICMP echo responder)
    input  logic        s0_ip_hdr_valid,
    output logic        s0_ip_hdr_ready,
    input  logic [5:0]  s0_ip_dscp,
    input  logic [1:0]  s0_ip_ecn,
    input  logic [15:0] s0_ip_length,
    input  logic [7:0]  s0_ip_ttl,
    input  logic [7:0]  s0_ip_protocol,
    input  logic [31:0] s0_ip_source_ip,
    input  logic [31:0] s0_ip_dest_ip,
    input  logic [7:0]  s0_ip_payload_axis_tdata,
    input  logic        s0_ip_payload_axis_tvalid,
    output logic        s0_ip_payload_axis_tready,
    input  logic        s0_ip_payload_axis_tlast,
    input  logic        s0_ip_payload_axis_tuser,

    // Source 1 (UDP / application)
    input  logic        s1_ip_hdr_valid,
    output logic        s1_ip_hdr_ready,
    input  logic [5:0]  s1_ip_dscp,
    input  logic [1:0]  s1_ip_ecn,
    input  logic [15:0] s1_ip_length,
    input  logic [7:0]  s1_ip_ttl,
    input  logic [7:0]  s1_ip_protocol,
    input  logic [31:0] s1_ip_source_ip,
    input  logic [31:0] s1_ip_dest_ip,
    input  logic [7:0]  s1_ip_payload_axis_tdata,
    input  logic        s1_ip_payload_axis_tvalid,
    output logic        s1_ip_payload_axis_tready,
    input  logic        s1_ip_payload_axis_tlast,
    input  logic        s1_ip_payload_axis_tuser,

    // Output towards the IP TX stack
    output logic        m_ip_hdr_valid,
    input  logic        m_ip_hdr_ready,
    output logic [5:0]  m_ip_dscp,
    output logic [1:0]  m_ip_ecn,
    output logic [15:0] m_ip_length,
    output logic [7:0]  m_ip_ttl,
    output logic [7:0]  m_ip_protocol,
    output logic [31:0] m_ip_source_ip,
    output logic [31:0] m_ip_dest_ip,
    output logic [7:0]  m_ip_payload_axis_tdata,
    output logic        m_ip_payload_axis_tvalid,
    input  logic        m_ip_payload_axis_tready,
    output logic        m_ip_payload_axis_tlast,
    output logic        m_ip_payload_axis_tuser,

    // Status
    output logic        busy,
    output logic        grant
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    state_t      state_q;
    logic        pref_q;
    logic        grant_q;
    logic        busy_q;
    logic        hdr_valid_q;
    logic [5:0]  dscp_q;
    logic [1:0]  ecn_q;
    logic [15:0] length_q;
    logic [7:0]  ttl_q;
    logic [7:0]  protocol_q;
    logic [31:0] source_ip_q;
    logic [31:0] dest_ip_q;

    logic        sel_d;
    logic        idle_en;
    logic        pay_en;
    logic        hdr_fire;
    logic        last_fire;
    logic [5:0]  dscp_d;
    logic [1:0]  ecn_d;
    logic [15:0] length_d;
    logic [7:0]  ttl_d;
    logic [7:0]  protocol_d;
    logic [31:0] source_ip_d;
    logic [31:0] dest_ip_d;

    // Readies are forced low while reset is held, independent of state.
    assign idle_en = rst && (state_q == ST_IDLE);
    assign pay_en  = rst && (state_q == ST_PAYLOAD);

    // Arbitration: a lone requester wins, otherwise the preferred port.
    always_comb begin
        sel_d = pref_q;
        if (s0_ip_hdr_valid && !s1_ip_hdr_valid) begin
            sel_d = 1'b0;
        end else if (s1_ip_hdr_valid && !s0_ip_hdr_valid) begin
            sel_d = 1'b1;
        end
    end

    assign s0_ip_hdr_ready = idle_en && !sel_d;
    assign s1_ip_hdr_ready = idle_en &&  sel_d;
    assign hdr_fire = (s0_ip_hdr_valid && s0_ip_hdr_ready) ||
                      (s1_ip_hdr_valid && s1_ip_hdr_ready);

    // Header fields of the selected port, captured on the handshake.
    always_comb begin
        dscp_d      = sel_d ? s1_ip_dscp      : s0_ip_dscp;
        ecn_d       = sel_d ? s1_ip_ecn       : s0_ip_ecn;
        length_d    = sel_d ? s1_ip_length    : s0_ip_length;
        ttl_d       = sel_d ? s1_ip_ttl       : s0_ip_ttl;
        protocol_d  = sel_d ? s1_ip_protocol  : s0_ip_protocol;
        source_ip_d = sel_d ? s1_ip_source_ip : s0_ip_source_ip;
        dest_ip_d   = sel_d ? s1_ip_dest_ip   : s0_ip_dest_ip;
    end

    // Zero-latency payload pass-through from the granted port; idle zeros otherwise.
    always_comb begin
        m_ip_payload_axis_tdata   = 8'd0;
        m_ip_payload_axis_tvalid  = 1'b0;
        m_ip_payload_axis_tlast   = 1'b0;
        m_ip_payload_axis_tuser   = 1'b0;
        s0_ip_payload_axis_tready = 1'b0;
        s1_ip_payload_axis_tready = 1'b0;
        if (pay_en) begin
            if (grant_q) begin
                m_ip_payload_axis_tdata   = s1_ip_payload_axis_tdata;
                m_ip_payload_axis_tvalid  = s1_ip_payload_axis_tvalid;
                m_ip_payload_axis_tlast   = s1_ip_payload_axis_tlast;
                m_ip_payload_axis_tuser   = s1_ip_payload_axis_tuser;
                s1_ip_payload_axis_tready = m_ip_payload_axis_tready;
            end else begin
                m_ip_payload_axis_tdata   = s0_ip_payload_axis_tdata;
                m_ip_payload_axis_tvalid  = s0_ip_payload_axis_tvalid;
                m_ip_payload_axis_tlast   = s0_ip_payload_axis_tlast;
                m_ip_payload_axis_tuser   = s0_ip_payload_axis_tuser;
                s0_ip_payload_axis_tready = m_ip_payload_axis_tready;
            end
        end
    end

    assign last_fire = m_ip_payload_axis_tvalid && m_ip_payload_axis_tready &&
                       m_ip_payload_axis_tlast;

    // Frame FSM: capture header, hand it downstream, stream payload to tlast.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pref_q      <= 1'b0;
            grant_q     <= 1'b0;
            busy_q      <= 1'b0;
            hdr_valid_q <= 1'b0;
            dscp_q      <= 6'd0;
            ecn_q       <= 2'd0;
            length_q    <= 16'd0;
            ttl_q       <= 8'd0;
            protocol_q  <= 8'd0;
            source_ip_q <= 32'd0;
            dest_ip_q   <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hdr_fire) begin
                        dscp_q      <= dscp_d;
                        ecn_q       <= ecn_d;
                        length_q    <= length_d;
                        ttl_q       <= ttl_d;
                        protocol_q  <= protocol_d;
                        source_ip_q <= source_ip_d;
                        dest_ip_q   <= dest_ip_d;
                        grant_q     <= sel_d;
                        hdr_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (m_ip_hdr_ready) begin
                        hdr_valid_q <= 1'b0;
                        state_q     <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (last_fire) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                        if (ROUND_ROBIN) begin
                            pref_q <= ~grant_q;
                        end
                    end
                end
                default: begin
                    hdr_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_ip_hdr_valid = hdr_valid_q;
    assign m_ip_dscp      = dscp_q;
    assign m_ip_ecn       = ecn_q;
    assign m_ip_length    = length_q;
    assign m_ip_ttl       = ttl_q;
    assign m_ip_protocol  = protocol_q;
    assign m_ip_source_ip = source_ip_q;
    assign m_ip_dest_ip   = dest_ip_q;
    assign busy           = busy_q;
    assign grant          = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_ip_tx_arb2.sv
`default_nettype none
// ============================================================================
// Module   : tb_ip_tx_arb2
// Purpose  : Scoreboard bench for ip_tx_arb2. Instance 0 round-robin,
//            instance 1 fixed priority. Frame order is predicted at issue time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ip_tx_arb2;

    typedef struct packed {
        logic [5:0]  dscp;
        logic [1:0]  ecn;
        logic [15:0] len;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [31:0] sip;
        logic [31:0] dip;
    } hdr_t;

    typedef struct packed {
        hdr_t             h;
        logic [4:0]       n;
        logic [15:0][7:0] d;
        logic [15:0]      u;
    } frame_t;

    typedef struct packed {
        logic port;
        hdr_t h;
    } exp_hdr_t;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    logic clk;
    logic rst_n [2];

    // Source side, index = 2*dut + port
    logic       hv [4];
    logic       hr [4];
    hdr_t       hd [4];
    logic [7:0] td [4];
    logic       tv [4];
    logic       tr [4];
    logic       tl [4];
    logic       tu [4];

    // Sink side, index = dut
    logic        mhv [2];
    logic        mhr [2];
    logic [5:0]  m_dscp [2];
    logic [1:0]  m_ecn [2];
    logic [15:0] m_len [2];
    logic [7:0]  m_ttl [2];
    logic [7:0]  m_proto [2];
    logic [31:0] m_sip [2];
    logic [31:0] m_dip [2];
    logic [7:0]  mtd [2];
    logic        mtv [2];
    logic        mtr [2];
    logic        mtl [2];
    logic        mtu [2];
    logic        busy [2];
    logic        grant [2];

    // Bench state
    frame_t   srcq [4][$];
    exp_hdr_t eh [2][$];
    beat_t    eb [2][$];
    frame_t   pend0 [$];
    frame_t   pend1 [$];
    frame_t   cur [4];
    int       sst [4];
    int       bi [4];
    logic     abort [2];
    int       mode [2];
    logic     pref_m [2];
    logic     in_pay [2];
    logic     cur_port [2];
    logic     hs_pend [2];
    int       beats_seen [2];
    int       errors;
    int       checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ip_tx_arb2 #(.ROUND_ROBIN(g == 0)) u_dut (
            .clk                       (clk),
            .rst                       (rst_n[g]),
            .s0_ip_hdr_valid           (hv[2*g]),
            .s0_ip_hdr_ready           (hr[2*g]),
            .s0_ip_dscp                (hd[2*g].dscp),
            .s0_ip_ecn                 (hd[2*g].ecn),
            .s0_ip_length              (hd[2*g].len),
            .s0_ip_ttl                 (hd[2*g].ttl),
            .s0_ip_protocol            (hd[2*g].proto),
            .s0_ip_source_ip           (hd[2*g].sip),
            .s0_ip_dest_ip             (hd[2*g].dip),
            .s0_ip_payload_axis_tdata  (td[2*g]),
            .s0_ip_payload_axis_tvalid (tv[2*g]),
            .s0_ip_payload_axis_tready (tr[2*g]),
            .s0_ip_payload_axis_tlast  (tl[2*g]),
            .s0_ip_payload_axis_tuser  (tu[2*g]),
            .s1_ip_hdr_valid           (hv[2*g+1]),
            .s1_ip_hdr_ready           (hr[2*g+1]),
            .s1_ip_dscp                (hd[2*g+1].dscp),
            .s1_ip_ecn                 (hd[2*g+1].ecn),
            .s1_ip_length              (hd[2*g+1].len),
            .s1_ip_ttl                 (hd[2*g+1].ttl),
            .s1_ip_protocol            (hd[2*g+1].proto),
            .s1_ip_source_ip           (hd[2*g+1].sip),
            .s1_ip_dest_ip             (hd[2*g+1].dip),
            .s1_ip_payload_axis_tdata  (td[2*g+1]),
            .s1_ip_payload_axis_tvalid (tv[2*g+1]),
            .s1_ip_payload_axis_tready (tr[2*g+1]),
            .s1_ip_payload_axis_tlast  (tl[2*g+1]),
            .s1_ip_payload_axis_tuser  (tu[2*g+1]),
            .m_ip_hdr_valid            (mhv[g]),
            .m_ip_hdr_ready            (mhr[g]),
            .m_ip_dscp                 (m_dscp[g]),
            .m_ip_ecn                  (m_ecn[g]),
            .m_ip_length               (m_len[g]),
            .m_ip_ttl                  (m_ttl[g]),
            .m_ip_protocol             (m_proto[g]),
            .m_ip_source_ip            (m_sip[g]),
            .m_ip_dest_ip              (m_dip[g]),
            .m_ip_payload_axis_tdata   (mtd[g]),
            .m_ip_payload_axis_tvalid  (mtv[g]),
            .m_ip_payload_axis_tready  (mtr[g]),
            .m_ip_payload_axis_tlast   (mtl[g]),
            .m_ip_payload_axis_tuser   (mtu[g]),
            .busy                      (busy[g]),
            .grant                     (grant[g])
        );
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic hdr_t got_hdr(input int d);
        return {m_dscp[d], m_ecn[d], m_len[d], m_ttl[d], m_proto[d], m_sip[d], m_dip[d]};
    endfunction

    function automatic frame_t rand_frame(input int n);
        frame_t f;
        f.h.dscp  = 6'($urandom);
        f.h.ecn   = 2'($urandom);
        f.h.len   = 16'($urandom);
        f.h.ttl   = 8'($urandom);
        f.h.proto = 8'($urandom);
        f.h.sip   = $urandom;
        f.h.dip   = $urandom;
        f.n       = 5'(n);
        for (int k = 0; k < 16; k++) begin
            f.d[k] = 8'($urandom);
            f.u[k] = ($urandom_range(0, 7) == 0);
        end
        return f;
    endfunction

    // Reference model: frame-level grant order from the arbitration rules,
    // expected headers and beats queued before the sources start.
    task automatic issue(input int d);
        int     a;
        int     b;
        logic   pick;
        frame_t f;
        beat_t  bt;
        a = 0;
        b = 0;
        while (a < pend0.size() || b < pend1.size()) begin
            if (a < pend0.size() && b < pend1.size()) pick = pref_m[d];
            else pick = (a < pend0.size()) ? 1'b0 : 1'b1;
            if (pick) begin f = pend1[b]; b++; end
            else      begin f = pend0[a]; a++; end
            eh[d].push_back({pick, f.h});
            for (int k = 0; k < int'(f.n); k++) begin
                bt.d = f.d[k];
                bt.l = (k == int'(f.n) - 1);
                bt.u = f.u[k];
                eb[d].push_back(bt);
            end
            if (d == 0) pref_m[d] = ~pick;
        end
        foreach (pend0[k]) srcq[2*d].push_back(pend0[k]);
        foreach (pend1[k]) srcq[2*d+1].push_back(pend1[k]);
        pend0.delete();
        pend1.delete();
    endtask

    task automatic present(input int i);
        td[i] = cur[i].d[bi[i]];
        tl[i] = (bi[i] == int'(cur[i].n) - 1);
        tu[i] = cur[i].u[bi[i]];
        tv[i] = ($urandom_range(0, 3) != 0);
    endtask

    // Source driver step, run #1 after each rising edge
    task automatic src_step(input int i, input logic fh, input logic fp);
        if (abort[i/2]) begin
            srcq[i].delete();
            sst[i] = 0;
            hv[i] = 1'b0; tv[i] = 1'b0; tl[i] = 1'b0; tu[i] = 1'b0; td[i] = 8'd0;
            return;
        end
        case (sst[i])
            1: if (fh) begin
                hv[i]  = 1'b0;
                sst[i] = 2;
                bi[i]  = 0;
                present(i);
            end
            2: begin
                if (fp) begin
                    if (bi[i] == int'(cur[i].n) - 1) begin
                        tv[i] = 1'b0; tl[i] = 1'b0; tu[i] = 1'b0;
                        sst[i] = 0;
                    end else begin
                        bi[i]++;
                        present(i);
                    end
                end else if (!tv[i]) begin
                    tv[i] = ($urandom_range(0, 3) != 0);
                end
            end
            default: ;
        endcase
        if (sst[i] == 0 && srcq[i].size() > 0) begin
            cur[i] = srcq[i].pop_front();
            hd[i]  = cur[i].h;
            hv[i]  = 1'b1;
            sst[i] = 1;
        end
    endtask

    for (genvar i = 0; i < 4; i++) begin : g_src
        initial begin
            logic fh;
            logic fp;
            hv[i] = 1'b0; tv[i] = 1'b0; tl[i] = 1'b0; tu[i] = 1'b0;
            td[i] = 8'd0; hd[i] = '0; sst[i] = 0; bi[i] = 0;
            forever begin
                @(negedge clk);
                fh = hv[i] && hr[i];
                fp = tv[i] && tr[i];
                @(posedge clk);
                #1;
                src_step(i, fh, fp);
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_snk
        initial begin
            int cnt;
            cnt = 0;
            mhr[g] = 1'b0;
            mtr[g] = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                case (mode[g])
                    1: begin mhr[g] = 1'b1; mtr[g] = 1'b1; end
                    2: begin
                        cnt = mhv[g] ? cnt + 1 : 0;
                        mhr[g] = (cnt >= 5);
                        mtr[g] = 1'b1;
                    end
                    3: begin mhr[g] = 1'b1; mtr[g] = ~mtr[g]; end
                    default: begin
                        mhr[g] = ($urandom_range(0, 1) == 1);
                        mtr[g] = ($urandom_range(0, 3) != 0);
                    end
                endcase
            end
        end
    end

    // Monitor step, run at the falling edge
    task automatic mon_step(input int d);
        logic  e0;
        logic  e1;
        beat_t bt;
        e0 = in_pay[d] && !cur_port[d] && mtr[d];
        e1 = in_pay[d] &&  cur_port[d] && mtr[d];
        chk("s0_tready", tr[2*d], e0);
        chk("s1_tready", tr[2*d+1], e1);
        chk("busy", busy[d], mhv[d] || in_pay[d]);
        if (mhv[d] || in_pay[d]) chk("hdr_ready_busy", {hr[2*d], hr[2*d+1]}, 2'b00);
        if (!in_pay[d]) chk("idle_payload", {mtv[d], mtl[d], mtu[d], mtd[d]}, 11'd0);
        if (hs_pend[d]) chk("hdr_latency", mhv[d], 1'b1);
        hs_pend[d] = (hv[2*d] && hr[2*d]) || (hv[2*d+1] && hr[2*d+1]);
        if (in_pay[d] && mtv[d] && mtr[d]) begin
            if (eb[d].size() == 0) begin
                chk("unexpected_beat", 1'b1, 1'b0);
            end else begin
                bt = eb[d].pop_front();
                chk("beat", {mtd[d], mtl[d], mtu[d]}, bt);
                beats_seen[d]++;
                if (mtl[d]) in_pay[d] = 1'b0;
            end
        end
        if (mhv[d]) begin
            if (eh[d].size() == 0) begin
                chk("unexpected_hdr", 1'b1, 1'b0);
            end else begin
                chk("hdr_fields", got_hdr(d), eh[d][0].h);
                chk("grant", grant[d], eh[d][0].port);
                if (mhr[d]) begin
                    cur_port[d] = eh[d][0].port;
                    void'(eh[d].pop_front());
                    in_pay[d] = 1'b1;
                end
            end
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_mon
        initial begin
            forever begin
                @(negedge clk);
                mon_step(g);
            end
        end
    end

    task automatic chk_zero(input int d);
        chk("rst_hdr_valid", mhv[d], 1'b0);
        chk("rst_hdr_fields", got_hdr(d), 104'd0);
        chk("rst_payload", {mtv[d], mtl[d], mtu[d], mtd[d]}, 11'd0);
        chk("rst_busy_grant", {busy[d], grant[d]}, 2'b00);
        chk("rst_readies", {hr[2*d], hr[2*d+1], tr[2*d], tr[2*d+1]}, 4'd0);
    endtask

    task automatic wait_done(input int d, input string nm);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        while (!done && n < 4000) begin
            @(posedge clk);
            #2;
            n++;
            done = srcq[2*d].size() == 0 && srcq[2*d+1].size() == 0 &&
                   sst[2*d] == 0 && sst[2*d+1] == 0 &&
                   eh[d].size() == 0 && eb[d].size() == 0 && !in_pay[d];
        end
        chk(nm, done, 1'b1);
    endtask

    initial begin
        frame_t f;
        int     n;
        errors = 0;
        checks = 0;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; abort[d] = 1'b0; mode[d] = 1; pref_m[d] = 1'b0;
            in_pay[d] = 1'b0; cur_port[d] = 1'b0; hs_pend[d] = 1'b0; beats_seen[d] = 0;
        end
        repeat (3) @(posedge clk);
        #2;
        chk_zero(0);
        chk_zero(1);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        repeat (2) @(posedge clk);

        // Single frame on port 0 with fixed header and bytes 0..7
        f = rand_frame(8);
        f.h.len = 16'h001C;
        f.h.dip = 32'hC0A80102;
        for (int k = 0; k < 8; k++) begin f.d[k] = 8'(k); f.u[k] = 1'b0; end
        pend0.push_back(f);
        issue(0);
        wait_done(0, "single_frame_timeout");

        // Reset asserted after 3 of 8 beats
        beats_seen[0] = 0;
        pend0.push_back(rand_frame(8));
        issue(0);
        n = 0;
        while (beats_seen[0] < 3 && n < 2000) begin @(posedge clk); n++; end
        chk("reset_wait_timeout", beats_seen[0] >= 3, 1'b1);
        @(posedge clk);
        #2;
        rst_n[0] = 1'b0;
        abort[0] = 1'b1;
        #1;
        chk_zero(0);
        eh[0].delete();
        eb[0].delete();
        in_pay[0] = 1'b0;
        hs_pend[0] = 1'b0;
        pref_m[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n[0] = 1'b1;
        abort[0] = 1'b0;
        #1;
        chk("post_reset_busy", busy[0], 1'b0);

        // Port 1 frame with tuser only on the tlast beat
        mode[0] = 0;
        f = rand_frame(5);
        f.u = 16'h0010;
        pend1.push_back(f);
        issue(0);
        wait_done(0, "tuser_frame_timeout");

        // Both ports pending, round-robin alternation
        for (int k = 0; k < 2; k++) begin
            pend0.push_back(rand_frame($urandom_range(1, 16)));
            pend1.push_back(rand_frame($urandom_range(1, 16)));
        end
        issue(0);
        wait_done(0, "rr_both_timeout");

        // Header backpressure held for several cycles
        mode[0] = 2;
        pend1.push_back(rand_frame(6));
        issue(0);
        wait_done(0, "hdr_hold_timeout");

        // Toggling payload ready
        mode[0] = 3;
        for (int k = 0; k < 3; k++) begin
            pend0.push_back(rand_frame($urandom_range(1, 16)));
            pend1.push_back(rand_frame($urandom_range(1, 16)));
        end
        issue(0);
        wait_done(0, "toggle_timeout");

        // Fixed priority instance: port 0 back-to-back while port 1 waits
        mode[1] = 0;
        for (int k = 0; k < 3; k++) pend0.push_back(rand_frame($urandom_range(1, 16)));
        for (int k = 0; k < 2; k++) pend1.push_back(rand_frame($urandom_range(1, 16)));
        issue(1);
        wait_done(1, "fixed_prio_timeout");

        // Random traffic on the round-robin instance
        mode[0] = 0;
        for (int k = 0; k < 5; k++) begin
            pend0.push_back(rand_frame($urandom_range(1, 16)));
            pend1.push_back(rand_frame($urandom_range(1, 16)));
        end
        issue(0);
        wait_done(0, "random_timeout");

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
